maxpool_stage: RTL and testbench
================================

# maxpool_stage

Layer-side responder for the CNN sequencer's per-stage enable. On a `start` pulse it sweeps a signed feature map in the layer buffer with non-overlapping 2x2 windows, writes each window maximum to the output buffer, and returns a one-cycle `done`. It sits between the sequencer, the upstream activation buffer and the downstream buffer, and serves both pooling stages through its parameters.

## Interface

Parameters:
- `DATA_W`, 16: signed sample width.
- `IN_H`, 28: input rows per channel.
- `IN_W`, 28: input columns per channel.
- `CH`, 1: channel count.
- `ADDR_W`, 16: buffer address width. Must hold `CH*IN_H*IN_W`.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: stage enable from the sequencer, sampled as a pulse.
- `busy`  out  1: a sweep is in progress.
- `done`  out  1: one-cycle pulse after the last write.
- `rd_en`  out  1: input buffer read strobe.
- `rd_addr`  out  ADDR_W: input read address.
- `rd_data`  in  DATA_W: input data, valid one cycle after `rd_en`.
- `wr_en`  out  1: output buffer write strobe.
- `wr_addr`  out  ADDR_W: output write address.
- `wr_data`  out  DATA_W: pooled value.

## Operation

- Output size: `OH = IN_H/2`, `OW = IN_W/2`, floor division. An odd trailing row or column is never read.
- Window order: channel outer, then row, then column inner.
- Input address of element (dy,dx): `ch*IN_H*IN_W + (2r+dy)*IN_W + 2c+dx`.
- Element order within a window: (0,0), (0,1), (1,0), (1,1).
- Output address: `ch*OH*OW + r*OW + c`, incrementing by 1 per window.
- States:
  - IDLE → R0 on `start`.
  - R0 → R1 → R2 → R3 → WR.
  - WR → R0 for the next window, or WR → DONE after the last window.
  - DONE → IDLE unconditionally.
- R0..R3: each state issues one read (`rd_en=1`).
- Running max register `acc`:
  - In R1, `acc` loads `rd_data`, the first element.
  - In R2 and R3, `acc = max(acc, rd_data)`.
  - In WR, `wr_data = max(acc, rd_data)` and `wr_en=1`.
- Compare is signed two's complement. Equal values keep `acc`. No width growth.
- `start` outside IDLE is ignored: no restart, no queueing.
- `busy` is high in R0..WR. It is low in IDLE and DONE.
- Degenerate size: if `OH==0` or `OW==0`, `start` goes IDLE → DONE with no reads or writes.

## Timing

- Reset values: every output is 0 and the state is IDLE. Address counters and `acc` are also 0.
- `rst` during a sweep: next cycle is IDLE, all strobes are low, no `done` is issued, and partial writes are left as they are.
- `rst` has priority over `start` in the same cycle.
- `start` high in cycle 0 puts the block in R0 in cycle 1.
- Each window takes 5 cycles. No bubbles between windows.
- The last `wr_en` is in cycle `5*CH*OH*OW`. `done` is high in the following cycle.
- Read data latency is exactly 1 cycle, and the block never stalls.
- At most one read and one write per cycle. Reads and writes never overlap in the same cycle.
- `done` and `busy` are never high together.
- A new `start` is accepted in the cycle after `done` (state IDLE).

## Configuration

- `MAXPOOL_RELU_EN`:
  - Defined: fused ReLU. The WR value is clamped, so a negative max is written as 0. Timing is unchanged.
  - Undefined: the raw signed max is written.

## Structure

- Shared package `cnn_pkg` holds:
  - the state encoding typedef `pool_state_t`;
  - the `DATA_W` default;
  - a signed `max2` function, reused by other layers.
- Sub-module `maxpool_addr_gen`:
  - holds the ch/r/c/dy/dx counters;
  - produces `rd_addr`, `wr_addr` and the `last_window` flag;
  - is advanced by the FSM.
- The top level holds the FSM, `acc`, the output registers and the ReLU option.

## Test plan

- Contiguous input: `IN_H=IN_W=4`, `CH=1`, buffer holds 0..15. Pulse `start` in cycle 0. Required: writes of 5, 7, 13, 15 to addresses 0..3, `done` in cycle 21, `busy` in cycles 1..20.
- Negative window: {-5, -3, -8, -1}. Required: write of -1 (0xFFFF). With `MAXPOOL_RELU_EN` defined, write of 0.
- Odd size: `IN_H=IN_W=5`, ramp 0..24. Required: writes 6, 8, 16, 18. No read ever touches row 4 or column 4. `done` in cycle 21.
- Multi-channel: `CH=2`, 4x4 ramp 0..31. Required: outputs 5, 7, 13, 15, 21, 23, 29, 31 at addresses 0..7, `done` in cycle 41.
- `start` while busy: a second `start` pulse in cycle 7. Required: no restart, the write sequence is unchanged, and exactly one `done`.
- Reset mid-sweep: `rst` in cycle 8. Required: IDLE and all outputs 0 from cycle 9, no `done`. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: pooling FSM states, default sample width
// and a signed max helper reused by other layers.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;

  // Width of the generic max2 operands; callers sign-extend into it and
  // truncate the result back to their own sample width.
  localparam int MAX2_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R0,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_WR,
    ST_DONE
  } pool_state_t;

  // Signed two's complement max; on a tie the first operand is kept.
  function automatic logic signed [MAX2_W-1:0] max2(
    input logic signed [MAX2_W-1:0] a,
    input logic signed [MAX2_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Address generator for the 2x2/stride-2 max-pool sweep. Walks windows in
// channel, row, column order and the four elements of each window in
// (0,0),(0,1),(1,0),(1,1) order. Window bases are kept incrementally so no
// multipliers are needed.
module maxpool_addr_gen #(
  parameter int IN_H   = 28,
  parameter int IN_W   = 28,
  parameter int CH     = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              elem_step,
  input  logic              win_step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_window
);

  localparam int OH = IN_H / 2;
  localparam int OW = IN_W / 2;

  localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(CH - 1);
  localparam logic [ADDR_W-1:0] R_LAST   = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] W_OFF    = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IN_W);
  localparam logic [ADDR_W-1:0] PLANE    = ADDR_W'(IN_H * IN_W);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(2);

  logic [ADDR_W-1:0] ch_q, r_q, c_q;
  logic              dy_q, dx_q;
  logic [ADDR_W-1:0] ch_base_q, row_base_q, win_base_q, wr_addr_q;

  assign last_window = (ch_q == CH_LAST) && (r_q == R_LAST) && (c_q == C_LAST);

  assign rd_addr = win_base_q + (dy_q ? W_OFF : '0) + {{(ADDR_W-1){1'b0}}, dx_q};
  assign wr_addr = wr_addr_q;

  // Element and window counters; everything returns to zero after the last window.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      dy_q       <= 1'b0;
      dx_q       <= 1'b0;
      ch_base_q  <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      wr_addr_q  <= '0;
    end else if (elem_step) begin
      {dy_q, dx_q} <= {dy_q, dx_q} + 2'd1;
    end else if (win_step) begin
      if (last_window) begin
        ch_q       <= '0;
        r_q        <= '0;
        c_q        <= '0;
        ch_base_q  <= '0;
        row_base_q <= '0;
        win_base_q <= '0;
        wr_addr_q  <= '0;
      end else begin
        wr_addr_q <= wr_addr_q + 1'b1;
        if (c_q != C_LAST) begin
          c_q        <= c_q + 1'b1;
          win_base_q <= win_base_q + COL_STEP;
        end else if (r_q != R_LAST) begin
          c_q        <= '0;
          r_q        <= r_q + 1'b1;
          row_base_q <= row_base_q + ROW_STEP;
          win_base_q <= row_base_q + ROW_STEP;
        end else begin
          c_q        <= '0;
          r_q        <= '0;
          ch_q       <= ch_q + 1'b1;
          ch_base_q  <= ch_base_q + PLANE;
          row_base_q <= ch_base_q + PLANE;
          win_base_q <= ch_base_q + PLANE;
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 signed max-pool stage driven by a one-cycle start pulse.
// Optional macro MAXPOOL_RELU_EN fuses a ReLU clamp onto the written value.
module maxpool_stage
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IN_H   = 28,
  parameter int IN_W   = 28,
  parameter int CH     = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int OH    = IN_H / 2;
  localparam int OW    = IN_W / 2;
  localparam bit EMPTY = (OH == 0) || (OW == 0) || (CH == 0);

  pool_state_t state_q, state_d;

  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] rd_s;
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] wr_val;
  logic [ADDR_W-1:0]        rd_addr_g, wr_addr_g;
  logic                     last_window;

  assign rd_s    = $signed(rd_data);
  assign win_max = DATA_W'(max2(MAX2_W'(acc_q), MAX2_W'(rd_s)));

`ifdef MAXPOOL_RELU_EN
  assign wr_val = win_max[DATA_W-1] ? '0 : win_max;
`else
  assign wr_val = win_max;
`endif

  maxpool_addr_gen #(
    .IN_H   (IN_H),
    .IN_W   (IN_W),
    .CH     (CH),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .elem_step   (rd_en),
    .win_step    (wr_en),
    .rd_addr     (rd_addr_g),
    .wr_addr     (wr_addr_g),
    .last_window (last_window)
  );

  // State register; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Running window maximum; data read in R0 arrives in R1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      case (state_q)
        ST_R1:        acc_q <= rd_s;
        ST_R2, ST_R3: acc_q <= win_max;
        default:      acc_q <= acc_q;
      endcase
    end
  end

  // Next-state and strobe decode; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = EMPTY ? ST_DONE : ST_R0;
      end
      ST_R0: begin
        busy = 1'b1; rd_en = 1'b1; state_d = ST_R1;
      end
      ST_R1: begin
        busy = 1'b1; rd_en = 1'b1; state_d = ST_R2;
      end
      ST_R2: begin
        busy = 1'b1; rd_en = 1'b1; state_d = ST_R3;
      end
      ST_R3: begin
        busy = 1'b1; rd_en = 1'b1; state_d = ST_WR;
      end
      ST_WR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        state_d = last_window ? ST_DONE : ST_R0;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses and data are held at zero whenever their strobe is low.
  assign rd_addr = rd_en ? rd_addr_g : '0;
  assign wr_addr = wr_en ? wr_addr_g : '0;
  assign wr_data = wr_en ? wr_val    : '0;

endmodule

// File: tb/tb_maxpool_stage.sv
// Scoreboard bench for maxpool_stage: dut0 is 4x4x2, dut1 is 5x5x1.
module tb_maxpool_stage;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] v;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          rst0, start0, busy0, done0, rd_en0, wr_en0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [DW-1:0] rd_data0 = '0, wr_data0;
  logic          rst1, start1, busy1, done1, rd_en1, wr_en1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] rd_data1 = '0, wr_data1;

  logic [DW-1:0] mem0 [32];
  logic [DW-1:0] mem1 [32];

  maxpool_stage #(.DATA_W(DW), .IN_H(4), .IN_W(4), .CH(2), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  maxpool_stage #(.DATA_W(DW), .IN_H(5), .IN_W(5), .CH(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  // One-cycle read latency buffer models
  always @(posedge clk) if (rd_en0) rd_data0 <= mem0[rd_addr0[4:0]];
  always @(posedge clk) if (rd_en1) rd_data1 <= mem1[rd_addr1[4:0]];

  int  checks = 0;
  int  errors = 0;
  wr_t q0[$];
  wr_t q1[$];
  int  t0[2], exp_done[2], done_cnt[2], busy_cnt[2], first_busy[2];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    wr_t e;
    e.a = a;
    e.v = v;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic arm(input int d, input int exp_d);
    t0[d]         = cyc;
    exp_done[d]   = exp_d;
    done_cnt[d]   = 0;
    busy_cnt[d]   = 0;
    first_busy[d] = -1;
  endtask

  task automatic mon(input int d, input logic busy, input logic done, input logic rd_en,
                     input logic wr_en, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd);
    int  rel;
    wr_t e;
    bit  have;
    rel = cyc - t0[d];
    if (busy) begin
      busy_cnt[d]++;
      if (first_busy[d] < 0) first_busy[d] = rel;
    end
    if (busy || done) begin
      check($sformatf("d%0d_rd_wr_excl", d), longint'(rd_en & wr_en), 0);
      check($sformatf("d%0d_busy_done_excl", d), longint'(busy & done), 0);
    end
    if (d == 1 && rd_en) begin
      check("d1_rd_row_lt4", longint'(ra / 16'd5 < 16'd4), 1);
      check("d1_rd_col_lt4", longint'(ra % 16'd5 < 16'd4), 1);
    end
    if (wr_en) begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL d%0d_wr_unexpected: got addr %0d data %0d, required no write", d, wa, wd);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_wr_addr", d), longint'(wa), longint'(e.a));
        check($sformatf("d%0d_wr_data", d), longint'(wd), longint'(e.v));
      end
    end
    if (done) begin
      done_cnt[d]++;
      check($sformatf("d%0d_done_cycle", d), rel, exp_done[d]);
      check($sformatf("d%0d_busy_cycles", d), busy_cnt[d], exp_done[d] - 1);
      check($sformatf("d%0d_first_busy", d), first_busy[d], 1);
    end
  endtask

  always @(negedge clk) mon(0, busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0);
  always @(negedge clk) mon(1, busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1);

  task automatic check_idle(input int d);
    if (d == 0) begin
      check("d0_idle_outs", longint'({busy0, done0, rd_en0, wr_en0}), 0);
      check("d0_idle_rd_addr", longint'(rd_addr0), 0);
      check("d0_idle_wr_addr", longint'(wr_addr0), 0);
      check("d0_idle_wr_data", longint'(wr_data0), 0);
    end else begin
      check("d1_idle_outs", longint'({busy1, done1, rd_en1, wr_en1}), 0);
      check("d1_idle_rd_addr", longint'(rd_addr1), 0);
      check("d1_idle_wr_addr", longint'(wr_addr1), 0);
      check("d1_idle_wr_data", longint'(wr_data1), 0);
    end
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 100 && done_cnt[d] == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check($sformatf("d%0d_done_count", d), done_cnt[d], 1);
    check($sformatf("d%0d_queue_drained", d), (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic push_ramp0();
    push(0, 16'd0, 16'd5);  push(0, 16'd1, 16'd7);
    push(0, 16'd2, 16'd13); push(0, 16'd3, 16'd15);
    push(0, 16'd4, 16'd21); push(0, 16'd5, 16'd23);
    push(0, 16'd6, 16'd29); push(0, 16'd7, 16'd31);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      t0[i] = 0; exp_done[i] = -1; done_cnt[i] = 0; busy_cnt[i] = 0; first_busy[i] = -1;
    end
    for (int i = 0; i < 32; i++) begin
      mem0[i] = 16'(i);
      mem1[i] = 16'(i);
    end
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check_idle(0);
    check_idle(1);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Ramps on both DUTs, plus a second start on dut0 while it is busy
    push_ramp0();
    push(1, 16'd0, 16'd6);  push(1, 16'd1, 16'd8);
    push(1, 16'd2, 16'd16); push(1, 16'd3, 16'd18);
    start0 = 1'b1; start1 = 1'b1; arm(0, 41); arm(1, 21);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    repeat (6) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1);
    wait_done(0);

    // Negative window and tie-heavy window on dut1
    mem1[0]  = -16'sd5;  mem1[1]  = -16'sd3; mem1[5]  = -16'sd8; mem1[6] = -16'sd1;
    mem1[10] = 16'd100;  mem1[11] = -16'sd7; mem1[15] = 16'd3;   mem1[16] = 16'd100;
`ifdef MAXPOOL_RELU_EN
    push(1, 16'd0, 16'h0000);
`else
    push(1, 16'd0, 16'hFFFF);
`endif
    push(1, 16'd1, 16'd8); push(1, 16'd2, 16'd100); push(1, 16'd3, 16'd18);
    start1 = 1'b1; arm(1, 21);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);

    // Reset in cycle 8 of a dut0 sweep: only window 0 is written, no done
    push(0, 16'd0, 16'd5);
    start0 = 1'b1; arm(0, -1);
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check_idle(0);
    repeat (10) @(negedge clk);
    check("d0_no_done_after_rst", done_cnt[0], 0);
    check("d0_rst_queue", q0.size(), 0);

    // Fresh sweep after the aborted one
    push_ramp0();
    start0 = 1'b1; arm(0, 41);
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);
    check_idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
